apb_to_axil_bridge: RTL and testbench
=====================================

# apb_to_axil_bridge

Reverse-direction bridge to the AXI4-Lite→APB bridge. It is an APB slave that converts each APB transfer into a single AXI4-Lite master transaction, and it lets APB-side peripherals or a debug master reach AXI4-Lite register space. It supports one outstanding transaction at a time, with no buffering beyond a single captured request and response. It sits between an APB interconnect (upstream) and an AXI4-Lite slave (downstream).

## Interface
- addrWidth, 32, address width on both sides
- dataWidth, 32, data width on both sides (multiple of 8)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- psel, penable, pwrite  in  1  APB control
- paddr  in  addrWidth  APB address
- pwdata  in  dataWidth  APB write data
- pstrb  in  dataWidth/8  APB4 write strobe
- pprot  in  3  APB4 protection
- pready  out  1  transfer complete
- prdata  out  dataWidth  read data
- pslverr  out  1  transfer error
- awvalid, wvalid, arvalid, bready, rready  out  1  AXI master handshakes
- awready, wready, arready, bvalid, rvalid  in  1  AXI slave handshakes
- awaddr, araddr  out  addrWidth  AXI addresses
- awprot, arprot  out  3  AXI protection
- wdata  out  dataWidth  AXI write data
- wstrb  out  dataWidth/8  AXI write strobe
- bresp, rresp  in  2  AXI responses
- rdata  in  dataWidth  AXI read data

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE, psel=1 and penable=0 (setup phase):
  - Register paddr, pwdata, pstrb, pprot.
  - Next state is WR_REQ if pwrite=1, else RD_REQ.
- WR_REQ: awvalid and wvalid are asserted together on entry. Each is deasserted independently on the cycle after its own handshake (valid & ready). Two flags record completion. When both flags are set, go to WR_RESP. AW and W may complete in the same cycle or in either order.
- WR_RESP: bready=1. On bvalid: capture pslverr = bresp[1] (SLVERR/DECERR→1, OKAY/EXOKAY→0), then go to DONE.
- RD_REQ: arvalid=1 until arready. Then go to RD_RESP.
- RD_RESP: rready=1. On rvalid: capture prdata=rdata and pslverr=rresp[1], then go to DONE.
- DONE: pready=1 for exactly one cycle, then go to IDLE. prdata holds its last captured value until the next read completes. A write does not modify prdata.
- Address, data and prot outputs are stable while their valid is high.
- If psel drops mid-transfer (APB protocol violation), the AXI transaction still completes and DONE still pulses. No AXI handshake is ever abandoned.
- A setup phase is not accepted in any state other than IDLE.

## Timing
- Reset values:
  - All AXI valids, bready, rready, pready and pslverr are 0.
  - prdata=0, awaddr/araddr=0, wdata=0, wstrb=0, awprot/arprot=0.
  - FSM is in IDLE.
- Reset mid-operation: every output returns to its reset value on the next edge. Any in-flight AXI handshake is dropped. The bench asserts rst only with the downstream slave also reset.
- Minimum write latency (setup at T0, awready/wready/bvalid held high):
  - Valids high at T1, handshake at T1.
  - bready at T2, response at T2.
  - pready at T3, which gives 2 APB wait states.
- Minimum read latency: arvalid at T1, rready at T2, pready at T3.
- Each cycle of slave backpressure adds exactly one cycle to latency.
- pready and pslverr are registered. pslverr is 0 whenever pready=0.

## Configuration
- BRIDGE_APB4_EN
  - Defined: wstrb=registered pstrb; awprot/arprot=registered pprot.
  - Undefined: pstrb and pprot are ignored (ports remain); wstrb is all ones; awprot/arprot=3'b000.
  - Read transfers never drive wstrb in either mode.

## Test plan
- Write, zero-wait slave: paddr=0x40, pwdata=0xDEADBEEF, pstrb=0xF; bresp=OKAY → awaddr=0x40, wdata=0xDEADBEEF, pready at T3, pslverr=0.
- Write, skewed handshakes: wready 3 cycles before awready; bvalid delayed 5 cycles → wvalid drops first, awvalid later, one pready pulse, no extra AW/W beat.
- Read with error: paddr=0x100; rdata=0x12345678, rresp=SLVERR after 4-cycle rvalid delay → prdata=0x12345678, pslverr=1 with pready only.
- Back-to-back: write 0x8/0xA5A5A5A5 then immediate read 0x8 returning 0xA5A5A5A5 → two non-overlapping AXI transactions, second setup accepted only after DONE.
- Reset mid-transfer: rst during WR_REQ with awready=0 → next edge awvalid=wvalid=0, FSM IDLE; a following read completes normally.
- Macro: without BRIDGE_APB4_EN, pstrb=0x3, pprot=3'b011 → wstrb=0xF, awprot=0. With the macro, the same stimulus gives wstrb=0x3, awprot=3'b011.

Source files
------------

// File: rtl/apb_to_axil_bridge.sv
// apb_to_axil_bridge: APB slave that turns each APB transfer into a single
// AXI4-Lite master transaction, one transaction in flight at a time.
// Build option: define BRIDGE_APB4_EN to forward pstrb/pprot to wstrb and
// awprot/arprot. Without it, wstrb is all ones and both prot outputs are 0.
// Handshake rule: an AXI beat transfers on a rising edge where valid and
// ready are both high. A valid, once raised, stays high with stable payload
// until that edge, and drops on the following cycle.
// state_dbg encoding: 0 IDLE, 1 WR_REQ, 2 WR_RESP, 3 RD_REQ, 4 RD_RESP, 5 DONE.
module apb_to_axil_bridge #(
   parameter int addrWidth = 32,
   parameter int dataWidth = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [addrWidth-1:0]     paddr,
   input  logic [dataWidth-1:0]     pwdata,
   input  logic [dataWidth/8-1:0]   pstrb,
   input  logic [2:0]               pprot,
   output logic                     pready,
   output logic [dataWidth-1:0]     prdata,
   output logic                     pslverr,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [addrWidth-1:0]     awaddr,
   output logic [2:0]               awprot,
   output logic                     wvalid,
   input  logic                     wready,
   output logic [dataWidth-1:0]     wdata,
   output logic [dataWidth/8-1:0]   wstrb,
   input  logic                     bvalid,
   output logic                     bready,
   input  logic [1:0]               bresp,
   output logic                     arvalid,
   input  logic                     arready,
   output logic [addrWidth-1:0]     araddr,
   output logic [2:0]               arprot,
   input  logic                     rvalid,
   output logic                     rready,
   input  logic [dataWidth-1:0]     rdata,
   input  logic [1:0]               rresp,
   output logic [2:0]               state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t state;
   logic   aw_done;
   logic   w_done;
   logic   aw_done_nxt;
   logic   w_done_nxt;

   // Only bit 1 of an AXI response separates errors (SLVERR/DECERR) from OKAY/EXOKAY.
   logic   resp_unused;
   assign resp_unused = bresp[0] ^ rresp[0];

`ifndef BRIDGE_APB4_EN
   // APB4 sideband pins stay on the port list but carry no meaning here.
   logic   apb4_unused;
   assign apb4_unused = ^{pstrb, pprot};
`endif

   // Completion flags including a handshake landing on the current edge.
   assign aw_done_nxt = aw_done | (awvalid & awready);
   assign w_done_nxt  = w_done  | (wvalid  & wready);
   assign state_dbg   = state;

   // Bridge FSM: captures the APB setup, drives the AXI channels, returns the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
         awaddr  <= '0;
         araddr  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
         awprot  <= 3'b000;
         arprot  <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (psel && !penable) begin
                  if (pwrite) begin
                     awaddr  <= paddr;
                     wdata   <= pwdata;
`ifdef BRIDGE_APB4_EN
                     wstrb   <= pstrb;
                     awprot  <= pprot;
`else
                     wstrb   <= '1;
                     awprot  <= 3'b000;
`endif
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                     state   <= WR_REQ;
                  end else begin
                     araddr  <= paddr;
`ifdef BRIDGE_APB4_EN
                     arprot  <= pprot;
`else
                     arprot  <= 3'b000;
`endif
                     arvalid <= 1'b1;
                     state   <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               // AW and W retire independently, in either order or together.
               if (awvalid && awready) awvalid <= 1'b0;
               if (wvalid && wready)   wvalid  <= 1'b0;
               aw_done <= aw_done_nxt;
               w_done  <= w_done_nxt;
               if (aw_done_nxt && w_done_nxt) begin
                  bready <= 1'b1;
                  state  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bvalid) begin
                  bready  <= 1'b0;
                  pslverr <= bresp[1];
                  pready  <= 1'b1;
                  state   <= DONE;
               end
            end
            RD_REQ: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (rvalid) begin
                  rready  <= 1'b0;
                  prdata  <= rdata;
                  pslverr <= rresp[1];
                  pready  <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               // One-cycle completion pulse; pslverr is only meaningful alongside it.
               pready  <= 1'b0;
               pslverr <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_to_axil_bridge.sv
// tb_apb_to_axil_bridge: directed and random APB transfers into the bridge,
// a delay-programmable AXI4-Lite memory slave, and a queue-based scoreboard.
// Honours BRIDGE_APB4_EN when computing expected strobes and prot.
module tb_apb_to_axil_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk;
   logic          rst;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [2:0]    pprot;
   logic          pready, pslverr;
   logic [DW-1:0] prdata;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;
   logic [2:0]    state_dbg;

   int errors = 0;
   int checks = 0;

   // Slave delay knobs, in cycles of backpressure per channel.
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

   // Scoreboard queues.
   logic [AW+2:0] exp_aw_q[$];   // {awprot, awaddr}
   logic [SW+DW-1:0] exp_w_q[$]; // {wstrb, wdata}
   logic [AW+2:0] exp_ar_q[$];   // {arprot, araddr}
   logic [DW:0]   exp_p_q[$];    // {pslverr, prdata}
   logic [1:0]    resp_plan_q[$];

   // Reference memory and the slave's own memory.
   logic [DW-1:0] ref_mem[logic [AW-1:0]];
   logic [DW-1:0] slv_mem[logic [AW-1:0]];
   logic [DW-1:0] last_rd = '0;

   apb_to_axil_bridge #(.addrWidth(AW), .dataWidth(DW)) dut (
      .clk(clk), .rst(rst),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .state_dbg(state_dbg)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [SW-1:0] exp_strb(input logic [SW-1:0] s);
`ifdef BRIDGE_APB4_EN
      return s;
`else
      return s | {SW{1'b1}};
`endif
   endfunction

   function automatic logic [2:0] exp_prot(input logic [2:0] p);
`ifdef BRIDGE_APB4_EN
      return p;
`else
      return p & 3'b000;
`endif
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [SW-1:0] s);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return '0;
   endfunction

   function automatic logic [DW-1:0] slv_read(input logic [AW-1:0] a);
      if (slv_mem.exists(a)) return slv_mem[a];
      return '0;
   endfunction

   task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   // Driver: one APB transfer, starting just after a rising edge.
   // lat = cycles from setup drive to the cycle pready is seen, inclusive.
   task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [2:0] pr,
                           input logic [1:0] resp, input int lat);
      int n;
      logic [DW-1:0] rd;
      resp_plan_q.push_back(resp);
      if (wr) begin
         exp_aw_q.push_back({exp_prot(pr), a});
         exp_w_q.push_back({exp_strb(s), d});
         ref_mem[a] = merge(ref_read(a), d, exp_strb(s));
         exp_p_q.push_back({resp[1], last_rd});
      end else begin
         exp_ar_q.push_back({exp_prot(pr), a});
         rd = ref_read(a);
         exp_p_q.push_back({resp[1], rd});
         last_rd = rd;
      end
      psel = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = a; pwdata = d; pstrb = s; pprot = pr;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 1;
      do begin
         @(negedge clk);
         n++;
      end while (!pready && n < 200);
      if (pready) check("latency", n, lat);
      else check("pready_timeout", 0, 1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   // AXI4-Lite memory slave with programmable per-channel delays.
   initial begin : slave
      logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
      logic got_aw, got_w, got_ar;
      logic [AW-1:0] s_awaddr, s_araddr;
      logic [DW-1:0] s_wdata;
      logic [SW-1:0] s_wstrb;
      int awc, wc, bc, arc, rc;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rresp = 0; rdata = '0;
      got_aw = 0; got_w = 0; got_ar = 0;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
      awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
      forever begin
         @(negedge clk);
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         hs_b  = bvalid && bready;
         hs_ar = arvalid && arready;
         hs_r  = rvalid && rready;
         if (hs_aw) s_awaddr = awaddr;
         if (hs_w) begin s_wdata = wdata; s_wstrb = wstrb; end
         if (hs_ar) s_araddr = araddr;
         @(posedge clk); #1;
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            got_aw = 0; got_w = 0; got_ar = 0;
            awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
         end else begin
            if (hs_aw) got_aw = 1;
            if (hs_w) got_w = 1;
            if (hs_ar) got_ar = 1;
            if (awvalid) begin awready = (awc >= aw_dly); awc++; end
            else begin awready = 0; awc = 0; end
            if (wvalid) begin wready = (wc >= w_dly); wc++; end
            else begin wready = 0; wc = 0; end
            if (arvalid) begin arready = (arc >= ar_dly); arc++; end
            else begin arready = 0; arc = 0; end
            if (hs_b) begin bvalid = 0; got_aw = 0; got_w = 0; bc = 0; end
            if (got_aw && got_w && !bvalid) begin
               if (bc >= b_dly) begin
                  bvalid = 1;
                  bresp = (resp_plan_q.size() > 0) ? resp_plan_q.pop_front() : 2'b00;
                  slv_mem[s_awaddr] = merge(slv_read(s_awaddr), s_wdata, s_wstrb);
               end else bc++;
            end
            if (hs_r) begin rvalid = 0; got_ar = 0; rc = 0; end
            if (got_ar && !rvalid) begin
               if (rc >= r_dly) begin
                  rvalid = 1;
                  rdata = slv_read(s_araddr);
                  rresp = (resp_plan_q.size() > 0) ? resp_plan_q.pop_front() : 2'b00;
               end else rc++;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a beat or a completion.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!pready) check("pslverr_without_pready", pslverr, 0);
            if ((arvalid || rready) && (awvalid || wvalid || bready))
               check("read_write_overlap", 1, 0);
            if (awvalid && awready) begin
               if (exp_aw_q.size() == 0) check("extra_aw_beat", 1, 0);
               else check("aw_beat", {awprot, awaddr}, exp_aw_q.pop_front());
            end
            if (wvalid && wready) begin
               if (exp_w_q.size() == 0) check("extra_w_beat", 1, 0);
               else check("w_beat", {wstrb, wdata}, exp_w_q.pop_front());
            end
            if (arvalid && arready) begin
               if (exp_ar_q.size() == 0) check("extra_ar_beat", 1, 0);
               else check("ar_beat", {arprot, araddr}, exp_ar_q.pop_front());
            end
            if (pready) begin
               if (exp_p_q.size() == 0) check("extra_pready", 1, 0);
               else check("apb_response", {pslverr, prdata}, exp_p_q.pop_front());
            end
         end
      end
   end

   // Reset-state checks shared by power-on and mid-transfer reset.
   task automatic check_reset_outputs(input string tag);
      check({tag, "_awvalid"}, awvalid, 0);
      check({tag, "_wvalid"}, wvalid, 0);
      check({tag, "_bready"}, bready, 0);
      check({tag, "_arvalid"}, arvalid, 0);
      check({tag, "_rready"}, rready, 0);
      check({tag, "_pready"}, pready, 0);
      check({tag, "_pslverr"}, pslverr, 0);
      check({tag, "_prdata"}, prdata, 0);
      check({tag, "_awaddr"}, awaddr, 0);
      check({tag, "_araddr"}, araddr, 0);
      check({tag, "_wdata"}, wdata, 0);
      check({tag, "_wstrb"}, wstrb, 0);
      check({tag, "_awprot"}, awprot, 0);
      check({tag, "_arprot"}, arprot, 0);
      check({tag, "_state_idle"}, state_dbg, 0);
   endtask

   // Stimulus
   initial begin : stimulus
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [2:0]    pr;
      logic [1:0]    rs;
      int            lat;
      psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      #2 rst = 1'b0;

      // Zero-wait write
      set_dly(0, 0, 0, 0, 0);
      apb_xfer(1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 4);
      // Skewed AW/W plus delayed B
      set_dly(3, 0, 5, 0, 0);
      apb_xfer(1, 32'h44, 32'h0BADF00D, 4'hF, 3'b000, 2'b00, 12);
      // Read with error after delayed R
      set_dly(0, 0, 0, 0, 0);
      apb_xfer(1, 32'h100, 32'h12345678, 4'hF, 3'b000, 2'b00, 4);
      set_dly(0, 0, 0, 0, 4);
      apb_xfer(0, 32'h100, '0, 4'h0, 3'b000, 2'b10, 8);
      // Back-to-back write then read, write carrying DECERR
      set_dly(0, 0, 0, 0, 0);
      apb_xfer(1, 32'h8, 32'hA5A5A5A5, 4'hF, 3'b000, 2'b11, 4);
      apb_xfer(0, 32'h8, '0, 4'h0, 3'b000, 2'b01, 4);
      // Strobe/prot handling
      apb_xfer(1, 32'h200, 32'hCAFEF00D, 4'h3, 3'b011, 2'b00, 4);
      apb_xfer(0, 32'h200, '0, 4'h0, 3'b011, 2'b00, 4);

      // Reset while stuck in WR_REQ with awready low
      set_dly(1000, 0, 0, 0, 0);
      exp_w_q.push_back({exp_strb(4'hF), 32'h11112222});
      psel = 1; penable = 0; pwrite = 1; paddr = 32'h300; pwdata = 32'h11112222;
      pstrb = 4'hF; pprot = 3'b000;
      @(posedge clk); #1;
      penable = 1;
      repeat (3) @(posedge clk);
      #1;
      check("stuck_awvalid", awvalid, 1);
      rst = 1'b1; psel = 0; penable = 0; pwrite = 0;
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      last_rd = '0;
      #2 rst = 1'b0;
      set_dly(0, 0, 0, 0, 0);
      apb_xfer(0, 32'h40, '0, 4'h0, 3'b000, 2'b00, 4);

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 15) * 4);
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         pr = 3'($urandom_range(0, 7));
         rs = 2'($urandom_range(0, 3));
         set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
         if (wr) lat = 4 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
         else    lat = 4 + ar_dly + r_dly;
         apb_xfer(wr, a, d, s, pr, rs, lat);
      end

      repeat (5) @(posedge clk);
      #1;
      check("aw_queue_drained", exp_aw_q.size(), 0);
      check("w_queue_drained", exp_w_q.size(), 0);
      check("ar_queue_drained", exp_ar_q.size(), 0);
      check("apb_queue_drained", exp_p_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
